// File: rtl/dc303_rdr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dc303_rdr : replays DC303 nanocommands to read MC or NA words.     |
// | Optional addr<64 short path: DC303_RDR_A64_EN.     Rev 1.0         |
// +--------------------------------------------------------------------+
module dc303_rdr #(
  parameter int HDIV     = 2,
  parameter int INIT_PER = 3
) (
  input  logic        pin_clk,
  input  logic        pin_rst,
  input  logic        req,
  input  logic        kind,
  input  logic [4:0]  chip,
  input  logic [9:0]  addr,
  input  logic [15:0] data,
  input  logic [3:0]  taa,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] dout,
  output logic        dc_clk,
  output logic        dc_rst,
  output logic        dc_ez_n,
  output logic [15:0] dc_ad,
  output logic [15:0] dc_m_out,
  output logic        dc_m_oe,
  input  logic [15:0] dc_m_in
);

  localparam logic [15:0] C_NOP    = 16'hD57F;
  localparam logic [15:0] C_LD     = 16'hD51F;
  localparam logic [15:0] C_AXT    = 16'hD50F;
  localparam logic [15:0] C_DUMMY  = 16'h8000;
  localparam logic [15:0] C_AD_PLA = 16'h0001;
  localparam logic [15:0] C_JMP    = 16'h07C0;
  localparam logic [15:0] C_L2     = 16'h8030;

  localparam int CW  = (HDIV > 1) ? $clog2(HDIV) : 1;
  localparam int SWI = $clog2(2 * INIT_PER + 1);
  localparam int SW  = (SWI > 4) ? SWI : 4;
  localparam logic [CW-1:0] C_HLAST     = CW'(HDIV - 1);
  localparam logic [SW-1:0] C_INIT_LAST = SW'(2 * INIT_PER - 1);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_WAKE = 3'd1,
    ST_IDLE = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic          kind_q, kind_d;
  logic [4:0]    chip_q, chip_d;
  logic [9:0]    addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic [3:0]    taa_q, taa_d;
`ifdef DC303_RDR_A64_EN
  logic          short_q, short_d;
`endif
  logic [15:0]   dout_q, dout_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dc_clk_q, dc_clk_d;
  logic          dc_rst_q, dc_rst_d;
  logic          dc_ez_n_q, dc_ez_n_d;
  logic [15:0]   dc_ad_q, dc_ad_d;
  logic [15:0]   dc_m_out_q, dc_m_out_d;
  logic          dc_m_oe_q, dc_m_oe_d;

  logic          step_end;
  logic [SW-1:0] run_last_cur, run_last_nxt;

  function automatic logic [15:0] with_b10(input logic [15:0] w, input logic k);
    logic [15:0] r;
    r     = w;
    r[10] = ~k;
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    hcnt_d       = hcnt_q;
    kind_d       = kind_q;
    chip_d       = chip_q;
    addr_d       = addr_q;
    data_d       = data_q;
    taa_d        = taa_q;
`ifdef DC303_RDR_A64_EN
    short_d      = short_q;
`endif
    dout_d       = dout_q;
    dc_clk_d     = dc_clk_q;
    dc_rst_d     = dc_rst_q;
    dc_ez_n_d    = dc_ez_n_q;
    dc_ad_d      = dc_ad_q;
    dc_m_out_d   = dc_m_out_q;
    dc_m_oe_d    = dc_m_oe_q;
    step_end     = (hcnt_q == C_HLAST);
    run_last_cur = kind_q ? SW'(11) : SW'(9);
`ifdef DC303_RDR_A64_EN
    if (short_q) run_last_cur = kind_q ? SW'(7) : SW'(5);
`endif

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_RUN;
          step_d  = '0;
          hcnt_d  = '0;
          kind_d  = kind;
          chip_d  = chip;
          addr_d  = addr;
          data_d  = data;
          taa_d   = taa;
`ifdef DC303_RDR_A64_EN
          short_d = (addr < 10'd64);
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        if (!step_end) begin
          hcnt_d = hcnt_q + 1'b1;
        end else begin
          hcnt_d = '0;
          step_d = step_q + 1'b1;
          if (state_q == ST_INIT && step_q == C_INIT_LAST) begin
            state_d = ST_WAKE;
            step_d  = '0;
          end else if (state_q == ST_WAKE && step_q == SW'(1)) begin
            state_d = ST_IDLE;
            step_d  = '0;
          end else if (state_q == ST_RUN && step_q == run_last_cur) begin
            state_d = ST_DONE;
            step_d  = '0;
            dout_d  = kind_q ? {6'b0, dc_m_in[9:0]} : dc_m_in;
          end
        end
      end
    endcase

    run_last_nxt = kind_d ? SW'(11) : SW'(9);
`ifdef DC303_RDR_A64_EN
    if (short_d) run_last_nxt = kind_d ? SW'(7) : SW'(5);
`endif

    // Pin values are decoded from the position being entered so they change together.
    case (state_d)
      ST_INIT: begin
        dc_clk_d  = ~step_d[0];
        dc_rst_d  = 1'b1;
        dc_ez_n_d = 1'b0;
        dc_m_oe_d = 1'b0;
      end
      ST_WAKE: begin
        dc_clk_d  = ~step_d[0];
        dc_rst_d  = 1'b0;
        dc_ez_n_d = 1'b1;
        dc_m_oe_d = 1'b0;
      end
      ST_IDLE: dc_clk_d = 1'b0;
      ST_RUN: begin
        dc_clk_d  = ~step_d[0];
        dc_rst_d  = 1'b0;
        dc_m_oe_d = 1'b1;
        dc_ez_n_d = 1'b0;
`ifdef DC303_RDR_A64_EN
        if (short_d) begin
          dc_ad_d = data_d;
          if (step_d == run_last_nxt) begin
            dc_m_oe_d = 1'b0;
            dc_ez_n_d = 1'b1;
          end else if (step_d == run_last_nxt - SW'(1)) begin
            dc_ez_n_d  = 1'b1;
            dc_m_out_d = with_b10(C_NOP, kind_d);
          end else begin
            case (step_d[2:0])
              3'd0:    dc_m_out_d = C_LD;
              3'd1:    dc_m_out_d = C_JMP;
              3'd3:    dc_m_out_d = {5'b0, chip_d, addr_d[5:0]};
              3'd5:    dc_m_out_d = C_DUMMY;
              default: dc_m_out_d = C_NOP;
            endcase
          end
        end else
`endif
        begin
          dc_ad_d = C_AD_PLA;
          if (step_d == run_last_nxt) begin
            dc_m_oe_d = 1'b0;
            dc_ez_n_d = 1'b1;
          end else if (step_d == run_last_nxt - SW'(1)) begin
            dc_ez_n_d  = 1'b1;
            dc_ad_d    = data_d;
            dc_m_out_d = with_b10(C_LD, kind_d);
          end else begin
            case (step_d)
              SW'(0):  dc_m_out_d = C_LD;
              SW'(1):  dc_m_out_d = C_JMP;
              SW'(2):  dc_m_out_d = C_NOP;
              SW'(3):  dc_m_out_d = {5'b0, chip_d, ~addr_d[9], 1'b1, taa_d};
              SW'(4):  dc_m_out_d = C_AXT;
              SW'(5):  dc_m_out_d = C_L2;
              SW'(6): begin
                dc_ad_d    = {6'b0, addr_d};
                dc_m_out_d = C_AXT;
              end
              SW'(8): begin
                dc_ad_d    = data_d;
                dc_m_out_d = C_LD;
              end
              default: dc_m_out_d = C_DUMMY;
            endcase
          end
        end
      end
      default: ;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_RUN) || (state_d == ST_DONE);
    done_d  = (state_d == ST_DONE);
  end

  // Reset parks one step before INIT step 0 so the first INIT step gets its full HDIV cycles.
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      state_q    <= ST_INIT;
      step_q     <= '1;
      hcnt_q     <= C_HLAST;
      kind_q     <= 1'b0;
      chip_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      taa_q      <= '0;
`ifdef DC303_RDR_A64_EN
      short_q    <= 1'b0;
`endif
      dout_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dc_clk_q   <= 1'b0;
      dc_rst_q   <= 1'b1;
      dc_ez_n_q  <= 1'b0;
      dc_ad_q    <= '0;
      dc_m_out_q <= '0;
      dc_m_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      hcnt_q     <= hcnt_d;
      kind_q     <= kind_d;
      chip_q     <= chip_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      taa_q      <= taa_d;
`ifdef DC303_RDR_A64_EN
      short_q    <= short_d;
`endif
      dout_q     <= dout_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dc_clk_q   <= dc_clk_d;
      dc_rst_q   <= dc_rst_d;
      dc_ez_n_q  <= dc_ez_n_d;
      dc_ad_q    <= dc_ad_d;
      dc_m_out_q <= dc_m_out_d;
      dc_m_oe_q  <= dc_m_oe_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign dout     = dout_q;
  assign dc_clk   = dc_clk_q;
  assign dc_rst   = dc_rst_q;
  assign dc_ez_n  = dc_ez_n_q;
  assign dc_ad    = dc_ad_q;
  assign dc_m_out = dc_m_out_q;
  assign dc_m_oe  = dc_m_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_dc303_rdr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dc303_rdr : directed + random reads against a step-list model.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_dc303_rdr;

  localparam int HDIV     = 2;
  localparam int INIT_PER = 3;

  localparam logic [15:0] NOP   = 16'hD57F;
  localparam logic [15:0] LD    = 16'hD51F;
  localparam logic [15:0] AXT   = 16'hD50F;
  localparam logic [15:0] DUMMY = 16'h8000;
  localparam logic [15:0] PLA   = 16'h0001;
  localparam logic [15:0] JMP   = 16'h07C0;

  logic        pin_clk = 1'b0;
  logic        pin_rst = 1'b1;
  logic        req     = 1'b0;
  logic        kind    = 1'b0;
  logic [4:0]  chip    = '0;
  logic [9:0]  addr    = '0;
  logic [15:0] data    = '0;
  logic [3:0]  taa     = '0;
  logic [15:0] dc_m_in = '0;
  logic        ready, busy, done, dc_clk, dc_rst, dc_ez_n, dc_m_oe;
  logic [15:0] dout, dc_ad, dc_m_out;

  dc303_rdr #(.HDIV(HDIV), .INIT_PER(INIT_PER)) dut (
    .pin_clk(pin_clk), .pin_rst(pin_rst), .req(req), .kind(kind), .chip(chip),
    .addr(addr), .data(data), .taa(taa), .ready(ready), .busy(busy), .done(done),
    .dout(dout), .dc_clk(dc_clk), .dc_rst(dc_rst), .dc_ez_n(dc_ez_n), .dc_ad(dc_ad),
    .dc_m_out(dc_m_out), .dc_m_oe(dc_m_oe), .dc_m_in(dc_m_in)
  );

  always #5 pin_clk = ~pin_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_dout = '0;

  typedef struct packed {
    logic [15:0] ad;
    logic [15:0] m;
    logic        oe;
    logic        ez_n;
    logic        mchk;
  } step_t;

  step_t plan[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic step_t mk(input logic [15:0] ad, input logic [15:0] m,
                               input logic oe, input logic ez_n, input logic mchk);
    step_t s;
    s.ad = ad; s.m = m; s.oe = oe; s.ez_n = ez_n; s.mchk = mchk;
    return s;
  endfunction

  function automatic logic [15:0] b10(input logic [15:0] w, input logic k);
    logic [15:0] r;
    r = w;
    r[10] = ~k;
    return r;
  endfunction

  // Expected pin sequence of one read, one entry per half-step.
  task automatic build_plan(input logic k, input logic [4:0] ch, input logic [9:0] a,
                            input logic [15:0] d, input logic [3:0] t);
    logic sh;
    sh = 1'b0;
`ifdef DC303_RDR_A64_EN
    sh = (a < 10'd64);
`endif
    plan = {};
    if (sh) begin
      plan.push_back(mk(d, LD, 1'b1, 1'b0, 1'b1));
      plan.push_back(mk(d, JMP, 1'b1, 1'b0, 1'b1));
      plan.push_back(mk(d, NOP, 1'b1, 1'b0, 1'b1));
      plan.push_back(mk(d, {5'b0, ch, a[5:0]}, 1'b1, 1'b0, 1'b1));
      if (k) begin
        plan.push_back(mk(d, NOP, 1'b1, 1'b0, 1'b1));
        plan.push_back(mk(d, DUMMY, 1'b1, 1'b0, 1'b1));
      end
      plan.push_back(mk(d, b10(NOP, k), 1'b1, 1'b1, 1'b1));
      plan.push_back(mk(d, 16'h0, 1'b0, 1'b1, 1'b0));
    end else begin
      plan.push_back(mk(PLA, LD, 1'b1, 1'b0, 1'b1));
      plan.push_back(mk(PLA, JMP, 1'b1, 1'b0, 1'b1));
      plan.push_back(mk(PLA, NOP, 1'b1, 1'b0, 1'b1));
      plan.push_back(mk(PLA, {5'b0, ch, ~a[9], 1'b1, t}, 1'b1, 1'b0, 1'b1));
      plan.push_back(mk(PLA, AXT, 1'b1, 1'b0, 1'b1));
      plan.push_back(mk(PLA, 16'h8030, 1'b1, 1'b0, 1'b1));
      plan.push_back(mk({6'b0, a}, AXT, 1'b1, 1'b0, 1'b1));
      plan.push_back(mk(PLA, DUMMY, 1'b1, 1'b0, 1'b1));
      if (k) begin
        plan.push_back(mk(d, LD, 1'b1, 1'b0, 1'b1));
        plan.push_back(mk(PLA, DUMMY, 1'b1, 1'b0, 1'b1));
      end
      plan.push_back(mk(d, b10(LD, k), 1'b1, 1'b1, 1'b1));
      plan.push_back(mk(PLA, 16'h0, 1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic do_reset(input string tag);
    int hs;
    logic in_init;
    pin_rst = 1'b1;
    req     = 1'b0;
    for (int r = 0; r < 2; r++) begin
      @(negedge pin_clk);
      check($sformatf("%s reset%0d", tag, r),
            {dc_clk, dc_rst, dc_ez_n, dc_m_oe, dc_ad, dc_m_out, ready, busy, done, dout},
            {1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0});
    end
    pin_rst   = 1'b0;
    last_dout = '0;
    for (int c = 1; c <= (2 * INIT_PER + 2) * HDIV; c++) begin
      @(negedge pin_clk);
      hs      = (c - 1) / HDIV;
      in_init = (hs < 2 * INIT_PER);
      check($sformatf("%s boot cyc%0d", tag, c),
            {dc_clk, dc_rst, dc_ez_n, dc_m_oe, dc_ad, dc_m_out, ready, busy, done},
            {((hs % 2) == 0), in_init, ~in_init, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0});
    end
    @(negedge pin_clk);
    check($sformatf("%s ready", tag), {ready, busy, done, dc_clk}, 4'b1000);
  endtask

  task automatic do_read(input string tag, input logic k, input logic [4:0] ch,
                         input logic [9:0] a, input logic [15:0] d, input logic [3:0] t,
                         input logic [15:0] mv, input int abort_at, input bit pulse_mid,
                         input bit hold_end, output int waited, output int done_at);
    int          lat;
    logic [15:0] exp_dout;
    step_t       s;
    logic        clk_e;
    build_plan(k, ch, a, d, t);
    lat      = plan.size() * HDIV + 1;
    exp_dout = k ? {6'b0, mv[9:0]} : mv;
    kind = k; chip = ch; addr = a; data = d; taa = t; req = 1'b1;
    waited  = 0;
    done_at = 0;
    while (ready !== 1'b1 && waited < 200) begin
      @(negedge pin_clk);
      waited++;
    end
    if (ready !== 1'b1) begin
      check($sformatf("%s ready timeout", tag), ready, 1);
      req = 1'b0;
      return;
    end
    @(posedge pin_clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge pin_clk);
      if (c < lat) begin
        s     = plan[(c - 1) / HDIV];
        clk_e = ((((c - 1) / HDIV) % 2) == 0);
        check($sformatf("%s cyc%0d", tag, c),
              {dc_clk, dc_rst, dc_ez_n, dc_m_oe, dc_ad, s.mchk ? dc_m_out : 16'h0, ready, busy, done, dout},
              {clk_e, 1'b0, s.ez_n, s.oe, s.ad, s.mchk ? s.m : 16'h0, 1'b0, 1'b1, 1'b0, last_dout});
      end else begin
        s = plan[plan.size() - 1];
        check($sformatf("%s done", tag),
              {dc_clk, dc_rst, dc_ez_n, dc_m_oe, dc_ad, ready, busy, done, dout},
              {1'b0, 1'b0, 1'b1, 1'b0, s.ad, 1'b0, 1'b1, 1'b1, exp_dout});
      end
      if (done === 1'b1 && done_at == 0) done_at = c;
      if (c == abort_at) begin
        pin_rst = 1'b1;
        return;
      end
      if (c == 1) req = 1'b0;
      if (c == 2) begin
        kind = 1'($urandom); chip = 5'($urandom); addr = 10'($urandom);
        data = 16'($urandom); taa = 4'($urandom);
      end
      if (pulse_mid && c == 3) req = 1'b1;
      if (pulse_mid && c == 4) req = 1'b0;
      if (hold_end && c == lat - 2) req = 1'b1;
      dc_m_in = (c == lat - 1) ? mv : (mv ^ (16'($urandom) | 16'h0201));
    end
    last_dout = exp_dout;
  endtask

  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  initial begin
    int          w, da;
    logic        rk;
    logic [9:0]  ra;
    do_reset("T1");

    do_read("T2", 1'b0, 5'd0, 10'h080, 16'h0000, 4'h5, 16'h1234, 0, 1'b0, 1'b0, w, da);
    check("T2 latency", da, 10 * HDIV + 1);
    check("T2 dout", dout, 16'h1234);

    do_read("T3", 1'b1, 5'd0, 10'h080, 16'hBEEF, 4'h5, 16'hFDFF, 0, 1'b0, 1'b0, w, da);
    check("T3 latency", da, 12 * HDIV + 1);
    check("T3 dout", dout, 16'h01FF);

    do_read("T4a", 1'b0, 5'd9, 10'h2F3, 16'h1357, 4'h3, 16'hA5C3, 0, 1'b1, 1'b1, w, da);
    do_read("T4b", 1'b1, 5'd17, 10'h3FF, 16'h2468, 4'hC, 16'h7E81, 0, 1'b0, 1'b0, w, da);
    check("T4 back-to-back wait", w, 1);
    check("T4b latency", da, 12 * HDIV + 1);

    do_read("T5a", 1'b0, 5'd4, 10'h155, 16'h0F0F, 4'h9, 16'h5555, 6 * HDIV + 1, 1'b0, 1'b0, w, da);
    check("T5 no done", da, 0);
    do_reset("T5");
    do_read("T5b", 1'b0, 5'd4, 10'h155, 16'h0F0F, 4'h9, 16'h5555, 0, 1'b0, 1'b0, w, da);

    do_read("T6", 1'b0, 5'd3, 10'h02A, 16'hC0DE, 4'h1, 16'h9ABC, 0, 1'b0, 1'b0, w, da);
`ifdef DC303_RDR_A64_EN
    check("T6 latency", da, 6 * HDIV + 1);
`else
    check("T6 latency", da, 10 * HDIV + 1);
`endif
    do_read("T6na", 1'b1, 5'd3, 10'h02A, 16'hC0DE, 4'h1, 16'h9ABC, 0, 1'b0, 1'b0, w, da);
`ifdef DC303_RDR_A64_EN
    check("T6na latency", da, 8 * HDIV + 1);
`else
    check("T6na latency", da, 12 * HDIV + 1);
`endif

    for (int i = 0; i < 16; i++) begin
      rk = 1'($urandom);
      if ($urandom_range(0, 1) == 1) ra = 10'($urandom_range(0, 63));
      else ra = 10'($urandom);
      do_read($sformatf("R%0d", i), rk, 5'($urandom), ra, 16'($urandom), 4'($urandom),
              16'($urandom), 0, 1'($urandom), 1'b0, w, da);
    end

    @(negedge pin_clk);
    check("idle after done", {ready, busy, done}, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
